// File: rtl/reg4_arb_pkg.sv
// Shared constants, FSM state type and round-robin pick helper for the
// four-requester register write arbiter.
package reg4_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_e;

    // First set bit of req searching upward from ptr+1, wrapping 3 -> 0.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reg4_en.sv
// WIDTH-bit register with load enable and synchronous active-high reset.
module reg4_en #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg4_write_arbiter.sv
// Round-robin arbiter granting one of four requesters a write into a shared
// register; each transaction runs IDLE -> WRITE -> ACK.
module reg4_write_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DATA,
    output logic [N_REQ-1:0]       GNT,
    output logic [WIDTH-1:0]       Q,
    output logic [1:0]             OWNER,
    output logic                   BUSY
);

    import reg4_arb_pkg::*;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               wr_en_q, wr_en_d;
    logic [IDX_W-1:0]   pick_c;
    logic [WIDTH-1:0]   pick_data_c;

    assign pick_c      = rr_pick(REQ, ptr_q);
    assign pick_data_c = DATA[32'(pick_c)*WIDTH +: WIDTH];

    // State and datapath registers; reset leaves requester 0 first in line.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            winner_q <= '0;
            data_q   <= '0;
            ptr_q    <= IDX_W'(N_REQ - 1);
            owner_q  <= '0;
            gnt_q    <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            data_q   <= data_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            wr_en_q  <= wr_en_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|REQ) state_d = WRITE;
            WRITE:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture at arbitration, register load from WRITE, grant/owner from ACK.
    always_comb begin
        winner_d = winner_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = '0;
        wr_en_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    winner_d = pick_c;
                    data_d   = pick_data_c;
                end
            end
            WRITE: begin
                wr_en_d = 1'b1;
            end
            ACK: begin
                gnt_d   = N_REQ'(1) << winner_q;
                ptr_d   = winner_q;
                owner_d = winner_q;
            end
            default: ;
        endcase
    end

    reg4_en #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk_i (CLK),
        .rst_i (RESET),
        .en_i  (wr_en_q),
        .d_i   (data_q),
        .q_o   (Q)
    );

    assign GNT   = gnt_q;
    assign OWNER = owner_q;
    assign BUSY  = (state_q != IDLE);

endmodule
